data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 14 +
 rtl/dmem_array.sv | 26 ++
 rtl/data_mem_responder.sv | 124 ++++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the data memory responder.
package mem_pkg;

  localparam int DATA_W              = 32;
  localparam int DEF_DEPTH           = 256;
  localparam int DEF_WAIT_CYCLES     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enabled write, asynchronous read. Not reset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding request/response memory with a fixed wait latency and
// alignment/range error detection.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = 64'(DEPTH) << 2;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              accept, commit;

  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_be;

  logic              a_we;
  logic [31:0]       a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [3:0]        a_be;
  logic              err;
  logic [DATA_W-1:0] rd_word;

  // With zero wait the access commits on the accept edge itself, so the
  // operands come straight from the request inputs rather than the latches.
  assign a_we    = accept ? req_we    : lat_we;
  assign a_addr  = accept ? req_addr  : lat_addr;
  assign a_wdata = accept ? req_wdata : lat_wdata;
  assign a_be    = accept ? req_be    : lat_be;

  assign err = (a_addr[1:0] != 2'b00) || (64'(a_addr) >= LIMIT);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (commit) begin
        resp_err   <= err;
        resp_rdata <= (a_we || err) ? '0 : rd_word;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (commit && a_we && !err),
    .be    (a_be),
    .addr  (a_addr[AW+1:2]),
    .wdata (a_wdata),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with WAIT_CYCLES=2, one with 0.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1 = 1'b0, req_ready1, req_we1 = 1'b0;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0;
  logic [3:0]  req_be1 = '0;
  logic        resp_valid1, resp_ready1 = 1'b1, resp_err1;
  logic [31:0] resp_rdata1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance; lat counts negedges
  // from the accept edge until resp_valid is seen.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata,
                      output logic err, output int lat);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] held;

  initial begin
    #1;
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_valid",  32'(resp_valid), 32'd0);
    check("rst_err",    32'(resp_err),   32'd0);
    check("rst_rdata",  resp_rdata,      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Basic write/read with latency
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("wr_lat",   32'(lat), 32'd3);
    check("wr_err",   32'(er),  32'd0);
    check("wr_rdata", rd,       32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("rd_lat",   32'(lat), 32'd3);
    check("rd_data",  rd,       32'hDEADBEEF);

    // Byte-lane merge
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("be_merge", rd, 32'h11BB33DD);

    // be=0000 is a legal no-op write
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    check("be0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("be0_data", rd, 32'h11BB33DD);

    // Error accesses
    xact(1'b1, 32'h0, 32'h01234567, 4'hF, rd, er, lat);
    xact(1'b0, 32'h22, 32'h0, 4'hF, rd, er, lat);
    check("mis_err",   32'(er), 32'd1);
    check("mis_rdata", rd,      32'd0);
    xact(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
    check("oor_err",   32'(er), 32'd1);
    check("oor_rdata", rd,      32'd0);
    xact(1'b1, 32'h401, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("oorw_err",  32'(er), 32'd1);
    xact(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    check("word0_kept", rd, 32'h01234567);
    xact(1'b0, 32'h3FC, 32'h0, 4'hF, rd, er, lat);
    check("last_word_err", 32'(er), 32'd0);

    // Backpressure with request inputs toggling (including a write to the same word)
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h20; req_be = 4'hF; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'h99999999; req_addr = 32'h24;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid = ~req_valid; req_addr = req_addr ^ 32'h4;
    end while (!resp_valid && lat < 20);
    check("bp_lat", 32'(lat), 32'd3);
    req_addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata,      32'h11BB33DD);
      check("bp_ready", 32'(req_ready),  32'd0);
      req_valid = ~req_valid; req_wdata = ~req_wdata;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("bp_no_write", rd, 32'h11BB33DD);
    xact(1'b0, 32'h24, 32'h0, 4'hF, rd, er, lat);
    check("bp_no_write2", 32'(er), 32'd0);

    // Reset during BUSY discards an uncommitted write
    xact(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("busy_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("arst_ready", 32'(req_ready),  32'd1);
    check("arst_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    xact(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    check("abort_lat",  32'(lat), 32'd3);
    check("abort_data", rd,       32'h0);

    // Reset while holding a response clears the registered outputs
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    held = resp_rdata;
    check("resp_hold", held, 32'hDEADBEEF);
    rst = 1'b0;
    #1;
    check("rresp_valid", 32'(resp_valid), 32'd0);
    check("rresp_rdata", resp_rdata,      32'd0);
    @(negedge clk) begin rst = 1'b1; resp_ready = 1'b1; end

    // Zero-wait instance: back-to-back with accepts every 2 cycles
    @(negedge clk);
    req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'h8; req_wdata1 = 32'hCAFEF00D;
    req_be1 = 4'hF; resp_ready1 = 1'b1;
    @(negedge clk);
    check("w0_valid1", 32'(resp_valid1), 32'd1);
    check("w0_ready1", 32'(req_ready1),  32'd0);
    check("w0_err1",   32'(resp_err1),   32'd0);
    req_we1 = 1'b0;
    @(negedge clk);
    check("w0_ready2", 32'(req_ready1),  32'd1);
    check("w0_valid2", 32'(resp_valid1), 32'd0);
    @(negedge clk);
    check("w0_valid3", 32'(resp_valid1), 32'd1);
    check("w0_rdata",  resp_rdata1,      32'hCAFEF00D);
    req_addr1 = 32'h6;
    @(negedge clk);
    check("w0_ready4", 32'(req_ready1),  32'd1);
    @(negedge clk);
    check("w0_mis_err", 32'(resp_err1),  32'd1);
    check("w0_mis_rd",  resp_rdata1,     32'd0);
    req_valid1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
